// File: rtl/decode_queue_pkg.sv
// Shared constants and types for the decode queue.
// Build option: DECODE_ILLEGAL_EN turns on strict illegal-encoding detection.
package decode_queue_pkg;

    localparam int unsigned INST_TYPE_WIDTH   = 6;
    localparam int unsigned OPCODE_WIDTH      = 7;
    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam int unsigned ADDRESS_WIDTH     = 32;
    localparam int unsigned REGISTER_WIDTH    = 5;

    localparam logic NULL    = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Decoded instruction types; TypeNull doubles as NOP / illegal marker
    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        TypeNull  = 6'd0,
        TypeLui   = 6'd1,
        TypeAuipc = 6'd2,
        TypeJal   = 6'd3,
        TypeJalr  = 6'd4,
        TypeBeq   = 6'd5,
        TypeBne   = 6'd6,
        TypeBlt   = 6'd7,
        TypeBge   = 6'd8,
        TypeBltu  = 6'd9,
        TypeBgeu  = 6'd10,
        TypeLb    = 6'd11,
        TypeLh    = 6'd12,
        TypeLw    = 6'd13,
        TypeLbu   = 6'd14,
        TypeLhu   = 6'd15,
        TypeSb    = 6'd16,
        TypeSh    = 6'd17,
        TypeSw    = 6'd18,
        TypeAddi  = 6'd19,
        TypeSlti  = 6'd20,
        TypeSltiu = 6'd21,
        TypeXori  = 6'd22,
        TypeOri   = 6'd23,
        TypeAndi  = 6'd24,
        TypeSlli  = 6'd25,
        TypeSrli  = 6'd26,
        TypeSrai  = 6'd27,
        TypeAdd   = 6'd28,
        TypeSub   = 6'd29,
        TypeSll   = 6'd30,
        TypeSlt   = 6'd31,
        TypeSltu  = 6'd32,
        TypeXor   = 6'd33,
        TypeSrl   = 6'd34,
        TypeSra   = 6'd35,
        TypeOr    = 6'd36,
        TypeAnd   = 6'd37
    } inst_type_e;

    // Operand/immediate layout selected by the opcode class
    typedef enum logic [2:0] {
        FmtNone,
        FmtR,
        FmtI,
        FmtShamt,
        FmtS,
        FmtB,
        FmtU,
        FmtJ
    } fmt_e;

    localparam logic [OPCODE_WIDTH-1:0] OpLui    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OpAuipc  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OpJal    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OpJalr   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OpBranch = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OpLoad   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OpStore  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OpImm    = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OpReg    = 7'b0110011;

endpackage

// File: rtl/inst_decode_comb.sv
// Combinational RV32I decoder: instruction type, register fields and immediate.
// Build option: DECODE_ILLEGAL_EN adds illegal_o and strict funct3/funct7 checks.
module inst_decode_comb
    import decode_queue_pkg::*;
(
    input  logic [INSTRUCTION_WIDTH-1:0] inst_i,
    output logic [INST_TYPE_WIDTH-1:0]   type_o,
    output logic [REGISTER_WIDTH-1:0]    rs1_o,
    output logic [REGISTER_WIDTH-1:0]    rs2_o,
    output logic [REGISTER_WIDTH-1:0]    rd_o,
`ifdef DECODE_ILLEGAL_EN
    output logic                         illegal_o,
`endif
    output logic [INSTRUCTION_WIDTH-1:0] imm_o
);

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [2:0]              funct3;
    inst_type_e              base_type;
    inst_type_e              dec_type;
    fmt_e                    base_fmt;
    fmt_e                    fmt;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // Opcode/funct3 to type and format; unrecognised encodings stay TypeNull
    always_comb begin
        base_type = TypeNull;
        base_fmt  = FmtNone;
        case (opcode)
            OpLui: begin
                base_type = TypeLui;
                base_fmt  = FmtU;
            end
            OpAuipc: begin
                base_type = TypeAuipc;
                base_fmt  = FmtU;
            end
            OpJal: begin
                base_type = TypeJal;
                base_fmt  = FmtJ;
            end
            OpJalr: begin
                base_fmt = FmtI;
                if (funct3 == 3'b000) base_type = TypeJalr;
            end
            OpBranch: begin
                base_fmt = FmtB;
                case (funct3)
                    3'b000:  base_type = TypeBeq;
                    3'b001:  base_type = TypeBne;
                    3'b100:  base_type = TypeBlt;
                    3'b101:  base_type = TypeBge;
                    3'b110:  base_type = TypeBltu;
                    3'b111:  base_type = TypeBgeu;
                    default: base_type = TypeNull;
                endcase
            end
            OpLoad: begin
                base_fmt = FmtI;
                case (funct3)
                    3'b000:  base_type = TypeLb;
                    3'b001:  base_type = TypeLh;
                    3'b010:  base_type = TypeLw;
                    3'b100:  base_type = TypeLbu;
                    3'b101:  base_type = TypeLhu;
                    default: base_type = TypeNull;
                endcase
            end
            OpStore: begin
                base_fmt = FmtS;
                case (funct3)
                    3'b000:  base_type = TypeSb;
                    3'b001:  base_type = TypeSh;
                    3'b010:  base_type = TypeSw;
                    default: base_type = TypeNull;
                endcase
            end
            OpImm: begin
                base_fmt = FmtI;
                case (funct3)
                    3'b000: base_type = TypeAddi;
                    3'b010: base_type = TypeSlti;
                    3'b011: base_type = TypeSltiu;
                    3'b100: base_type = TypeXori;
                    3'b110: base_type = TypeOri;
                    3'b111: base_type = TypeAndi;
                    3'b001: begin
                        base_type = TypeSlli;
                        base_fmt  = FmtShamt;
                    end
                    default: begin
                        base_type = inst_i[30] ? TypeSrai : TypeSrli;
                        base_fmt  = FmtShamt;
                    end
                endcase
            end
            OpReg: begin
                base_fmt = FmtR;
                case (funct3)
                    3'b000:  base_type = inst_i[30] ? TypeSub : TypeAdd;
                    3'b001:  base_type = TypeSll;
                    3'b010:  base_type = TypeSlt;
                    3'b011:  base_type = TypeSltu;
                    3'b100:  base_type = TypeXor;
                    3'b101:  base_type = inst_i[30] ? TypeSra : TypeSrl;
                    3'b110:  base_type = TypeOr;
                    default: base_type = TypeAnd;
                endcase
            end
            default: begin
                base_type = TypeNull;
                base_fmt  = FmtNone;
            end
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    logic f7_checked;
    logic f7_bad;

    // funct7 must be 0000000 or 0100000 wherever it selects between two operations
    assign f7_checked = ((opcode == OpReg) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                        ((opcode == OpImm) && (funct3 == 3'b101));
    assign f7_bad     = f7_checked && (inst_i[31:25] != 7'b0000000) &&
                        (inst_i[31:25] != 7'b0100000);
    assign illegal_o  = (base_type == TypeNull) || f7_bad;
    assign dec_type   = illegal_o ? TypeNull : base_type;
`else
    assign dec_type   = base_type;
`endif

    // A NULL type carries no operands, so every field reads NULL
    assign fmt    = (dec_type == TypeNull) ? FmtNone : base_fmt;
    assign type_o = dec_type;

    // Field and immediate extraction per format
    always_comb begin
        rs1_o = '0;
        rs2_o = '0;
        rd_o  = '0;
        imm_o = '0;
        case (fmt)
            FmtR: begin
                rd_o  = inst_i[11:7];
                rs1_o = inst_i[19:15];
                rs2_o = inst_i[24:20];
            end
            FmtI: begin
                rd_o  = inst_i[11:7];
                rs1_o = inst_i[19:15];
                imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            FmtShamt: begin
                rd_o  = inst_i[11:7];
                rs1_o = inst_i[19:15];
                imm_o = {26'b0, inst_i[25:20]};
            end
            FmtS: begin
                rs1_o = inst_i[19:15];
                rs2_o = inst_i[24:20];
                imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            FmtB: begin
                rs1_o = inst_i[19:15];
                rs2_o = inst_i[24:20];
                imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
            end
            FmtU: begin
                rd_o  = inst_i[11:7];
                imm_o = {inst_i[31:12], 12'b0};
            end
            FmtJ: begin
                rd_o  = inst_i[11:7];
                imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
            end
            default: begin
                rd_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: decodes pushed instructions into a circular buffer of DEPTH
// entries, popped by the dispatcher with valid/ready; a ROB flush empties it.
// Build option: DECODE_ILLEGAL_EN stores an illegal flag per entry.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         rob_flush_in,
    input  logic                         instqueue_inst_en,
    input  logic [INSTRUCTION_WIDTH-1:0] instqueue_inst_in,
    input  logic [ADDRESS_WIDTH-1:0]     instqueue_pc_in,
    output logic                         instqueue_ready_out,
    output logic                         dispatcher_en_out,
    input  logic                         dispatcher_ready_in,
    output logic [INST_TYPE_WIDTH-1:0]   dispatcher_inst_type_out,
    output logic [REGISTER_WIDTH-1:0]    dispatcher_rs1_out,
    output logic [REGISTER_WIDTH-1:0]    dispatcher_rs2_out,
    output logic [REGISTER_WIDTH-1:0]    dispatcher_rd_out,
    output logic [INSTRUCTION_WIDTH-1:0] dispatcher_imm_out,
    output logic [ADDRESS_WIDTH-1:0]     dispatcher_pc_out,
    output logic                         dispatcher_illegal_out,
    output logic [PTR_W:0]               count_out
);

    localparam logic [PTR_W:0]   CountFull = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CountOne  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push;
    logic             pop;

    logic [INST_TYPE_WIDTH-1:0]   dec_type;
    logic [REGISTER_WIDTH-1:0]    dec_rs1;
    logic [REGISTER_WIDTH-1:0]    dec_rs2;
    logic [REGISTER_WIDTH-1:0]    dec_rd;
    logic [INSTRUCTION_WIDTH-1:0] dec_imm;

    logic [INST_TYPE_WIDTH-1:0]   type_q [DEPTH];
    logic [REGISTER_WIDTH-1:0]    rs1_q  [DEPTH];
    logic [REGISTER_WIDTH-1:0]    rs2_q  [DEPTH];
    logic [REGISTER_WIDTH-1:0]    rd_q   [DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] imm_q  [DEPTH];
    logic [ADDRESS_WIDTH-1:0]     pc_q   [DEPTH];

`ifdef DECODE_ILLEGAL_EN
    logic dec_illegal;
    logic illegal_q [DEPTH];
`endif

    inst_decode_comb u_decode (
        .inst_i    (instqueue_inst_in),
        .type_o    (dec_type),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .rd_o      (dec_rd),
`ifdef DECODE_ILLEGAL_EN
        .illegal_o (dec_illegal),
`endif
        .imm_o     (dec_imm)
    );

    // No pop-to-push bypass: a full buffer refuses even while popping
    assign instqueue_ready_out = (count_q != CountFull);
    assign dispatcher_en_out   = (count_q != '0);
    assign count_out           = count_q;

    assign push = !rst_in && !rob_flush_in && rdy_in && instqueue_inst_en &&
                  instqueue_ready_out;
    assign pop  = !rst_in && !rob_flush_in && rdy_in && dispatcher_en_out &&
                  dispatcher_ready_in;

    // Pointer and occupancy next state; flush drops any same-cycle push/pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rob_flush_in) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PtrOne;
            if (pop)  head_d = head_q + PtrOne;
            case ({push, pop})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot storage; contents are only observable while counted, so no reset needed
    always_ff @(posedge clk_in) begin
        if (push) begin
            type_q[tail_q]    <= dec_type;
            rs1_q[tail_q]     <= dec_rs1;
            rs2_q[tail_q]     <= dec_rs2;
            rd_q[tail_q]      <= dec_rd;
            imm_q[tail_q]     <= dec_imm;
            pc_q[tail_q]      <= instqueue_pc_in;
`ifdef DECODE_ILLEGAL_EN
            illegal_q[tail_q] <= dec_illegal;
`endif
        end
    end

    // Head entry to the dispatcher, forced to NULL while empty
    always_comb begin
        dispatcher_inst_type_out = '0;
        dispatcher_rs1_out       = '0;
        dispatcher_rs2_out       = '0;
        dispatcher_rd_out        = '0;
        dispatcher_imm_out       = '0;
        dispatcher_pc_out        = '0;
        dispatcher_illegal_out   = 1'b0;
        if (dispatcher_en_out) begin
            dispatcher_inst_type_out = type_q[head_q];
            dispatcher_rs1_out       = rs1_q[head_q];
            dispatcher_rs2_out       = rs2_q[head_q];
            dispatcher_rd_out        = rd_q[head_q];
            dispatcher_imm_out       = imm_q[head_q];
            dispatcher_pc_out        = pc_q[head_q];
`ifdef DECODE_ILLEGAL_EN
            dispatcher_illegal_out   = illegal_q[head_q];
`endif
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4), covering decode of each format, fill/wrap,
// push+pop, flush under rdy_in low and reset mid-run. Honours DECODE_ILLEGAL_EN.
module tb_decode_queue;
    import decode_queue_pkg::*;

`ifdef DECODE_ILLEGAL_EN
    localparam logic IllegalEn = 1'b1;
`else
    localparam logic IllegalEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        in_en = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready;
    logic        d_en;
    logic        d_ready = 1'b0;
    logic [5:0]  d_type;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic [31:0] d_imm;
    logic [31:0] d_pc;
    logic        d_illegal;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    decode_queue #(.DEPTH(4)) dut (
        .clk_in                   (clk),
        .rst_in                   (rst),
        .rdy_in                   (rdy),
        .rob_flush_in             (flush),
        .instqueue_inst_en        (in_en),
        .instqueue_inst_in        (in_inst),
        .instqueue_pc_in          (in_pc),
        .instqueue_ready_out      (in_ready),
        .dispatcher_en_out        (d_en),
        .dispatcher_ready_in      (d_ready),
        .dispatcher_inst_type_out (d_type),
        .dispatcher_rs1_out       (d_rs1),
        .dispatcher_rs2_out       (d_rs2),
        .dispatcher_rd_out        (d_rd),
        .dispatcher_imm_out       (d_imm),
        .dispatcher_pc_out        (d_pc),
        .dispatcher_illegal_out   (d_illegal),
        .count_out                (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decode vectors: inst, type, rs1, rs2, rd, imm
    localparam int NVec = 9;
    logic [31:0] tv_inst [NVec] = '{32'h00500093, 32'hFFC12083, 32'h00512423, 32'hFE208CE3,
                                    32'h123451B7, 32'h010000EF, 32'h40315093, 32'h402081B3,
                                    32'hFFFFFFFF};
    logic [5:0]  tv_type [NVec] = '{TypeAddi, TypeLw, TypeSw, TypeBeq, TypeLui, TypeJal,
                                    TypeSrai, TypeSub, TypeNull};
    logic [4:0]  tv_rs1  [NVec] = '{5'd0, 5'd2, 5'd2, 5'd1, 5'd0, 5'd0, 5'd2, 5'd1, 5'd0};
    logic [4:0]  tv_rs2  [NVec] = '{5'd0, 5'd0, 5'd5, 5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0};
    logic [4:0]  tv_rd   [NVec] = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd3, 5'd1, 5'd1, 5'd3, 5'd0};
    logic [31:0] tv_imm  [NVec] = '{32'd5, 32'hFFFFFFFC, 32'd8, 32'hFFFFFFF8, 32'h12345000,
                                    32'd16, 32'd3, 32'd0, 32'd0};

    initial begin
        step();
        step();
        rst = 1'b0;
        check("reset_en", {31'b0, d_en}, 32'd0);
        check("reset_ready", {31'b0, in_ready}, 32'd1);
        check("reset_count", {29'b0, count}, 32'd0);
        check("reset_type", {26'b0, d_type}, 32'd0);
        check("reset_pc", d_pc, 32'd0);

        // One instruction at a time through an empty buffer
        for (int i = 0; i < NVec; i++) begin
            in_en   = 1'b1;
            in_inst = tv_inst[i];
            in_pc   = 32'h100 + 32'(4 * i);
            step();
            in_en = 1'b0;
            check($sformatf("v%0d_en", i), {31'b0, d_en}, 32'd1);
            check($sformatf("v%0d_count", i), {29'b0, count}, 32'd1);
            check($sformatf("v%0d_type", i), {26'b0, d_type}, {26'b0, tv_type[i]});
            check($sformatf("v%0d_rs1", i), {27'b0, d_rs1}, {27'b0, tv_rs1[i]});
            check($sformatf("v%0d_rs2", i), {27'b0, d_rs2}, {27'b0, tv_rs2[i]});
            check($sformatf("v%0d_rd", i), {27'b0, d_rd}, {27'b0, tv_rd[i]});
            check($sformatf("v%0d_imm", i), d_imm, tv_imm[i]);
            check($sformatf("v%0d_pc", i), d_pc, 32'h100 + 32'(4 * i));
            check($sformatf("v%0d_illegal", i), {31'b0, d_illegal},
                  {31'b0, (i == NVec - 1) ? IllegalEn : 1'b0});
            d_ready = 1'b1;
            step();
            d_ready = 1'b0;
            check($sformatf("v%0d_popped", i), {29'b0, count}, 32'd0);
        end

        // Fill with the dispatcher stalled; head starts at slot 1, so the tail wraps
        in_inst = 32'h00500093;
        for (int i = 0; i < 4; i++) begin
            in_en = 1'b1;
            in_pc = 32'h200 + 32'(4 * i);
            step();
        end
        check("fill_count", {29'b0, count}, 32'd4);
        check("fill_ready", {31'b0, in_ready}, 32'd0);
        in_pc = 32'h210;
        step();
        check("fill_refused", {29'b0, count}, 32'd4);
        // Full with a pop: the push is still refused
        in_pc   = 32'h214;
        d_ready = 1'b1;
        check("fill_head0", d_pc, 32'h200);
        step();
        in_en = 1'b0;
        check("full_pushpop_count", {29'b0, count}, 32'd3);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("wrap_pc%0d", i), d_pc, 32'h200 + 32'(4 * i));
            step();
        end
        check("wrap_empty", {31'b0, d_en}, 32'd0);
        d_ready = 1'b0;

        // Simultaneous push and pop at count 2
        for (int i = 0; i < 2; i++) begin
            in_en = 1'b1;
            in_pc = 32'h300 + 32'(4 * i);
            step();
        end
        check("pp_count_before", {29'b0, count}, 32'd2);
        in_pc   = 32'h308;
        d_ready = 1'b1;
        step();
        in_en = 1'b0;
        check("pp_count", {29'b0, count}, 32'd2);
        check("pp_head1", d_pc, 32'h304);
        step();
        check("pp_head2", d_pc, 32'h308);
        check("pp_count1", {29'b0, count}, 32'd1);
        step();
        check("pp_empty", {29'b0, count}, 32'd0);
        d_ready = 1'b0;

        // rdy_in low freezes, then flush wins over rdy_in low and drops the push
        for (int i = 0; i < 3; i++) begin
            in_en = 1'b1;
            in_pc = 32'h500 + 32'(4 * i);
            step();
        end
        rdy     = 1'b0;
        in_pc   = 32'h50C;
        d_ready = 1'b1;
        step();
        check("frz_count", {29'b0, count}, 32'd3);
        check("frz_head", d_pc, 32'h500);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_en = 1'b0;
        check("flush_count", {29'b0, count}, 32'd0);
        check("flush_en", {31'b0, d_en}, 32'd0);
        check("flush_ready", {31'b0, in_ready}, 32'd1);
        rdy = 1'b1;
        step();
        check("flush_absent", {31'b0, d_en}, 32'd0);
        d_ready = 1'b0;
        in_en   = 1'b1;
        in_pc   = 32'h600;
        step();
        in_en = 1'b0;
        check("post_flush_pc", d_pc, 32'h600);
        check("post_flush_count", {29'b0, count}, 32'd1);

        // Reset mid-operation discards held entries
        in_en = 1'b1;
        in_pc = 32'h700;
        step();
        in_en = 1'b0;
        check("pre_rst_count", {29'b0, count}, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_en", {31'b0, d_en}, 32'd0);
        check("rst_imm", d_imm, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
